// File: rtl/hazard_pkg.sv
// Shared types and constants for the multi-cycle ID-stage hazard unit.
package hazard_pkg;

    localparam int HZ_ADDR_WIDTH  = 5;
    localparam int HZ_FLUSH_CNT_W = 3;
    localparam logic [HZ_ADDR_WIDTH-1:0] HZ_REG_ZERO = '0;

    typedef struct packed {
        logic                     valid;
        logic [HZ_ADDR_WIDTH-1:0] addr;
    } ld_entry_t;

endpackage

// File: rtl/load_inflight_tracker.sv
// Shift register of in-flight load destinations plus match logic for both ID sources.
// The EX-stage load is always part of the pending set; DEPTH=0 leaves only that check.
module load_inflight_tracker
    import hazard_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ld_valid,
    input  logic [HZ_ADDR_WIDTH-1:0] ld_addr,
    input  logic [HZ_ADDR_WIDTH-1:0] src_s,
    input  logic [HZ_ADDR_WIDTH-1:0] src_t,
    output logic                     match_s,
    output logic                     match_t
);

    ld_entry_t        ex_ent;
    logic [DEPTH:0]   hit_s;
    logic [DEPTH:0]   hit_t;

    // r0 loads never become pending, so a match implies a nonzero source.
    assign ex_ent   = '{valid: ld_valid && (ld_addr != HZ_REG_ZERO), addr: ld_addr};
    assign hit_s[0] = ex_ent.valid && (ex_ent.addr == src_s);
    assign hit_t[0] = ex_ent.valid && (ex_ent.addr == src_t);

    generate
        if (DEPTH > 0) begin : g_trk
            ld_entry_t [DEPTH-1:0] ld_pipe;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ld_pipe <= '0;
                end else begin
                    ld_pipe[0] <= ex_ent;
                    for (int i = 1; i < DEPTH; i++) ld_pipe[i] <= ld_pipe[i-1];
                end
            end

            for (genvar i = 0; i < DEPTH; i++) begin : g_hit
                assign hit_s[i+1] = ld_pipe[i].valid && (ld_pipe[i].addr == src_s);
                assign hit_t[i+1] = ld_pipe[i].valid && (ld_pipe[i].addr == src_t);
            end
        end
    endgenerate

    assign match_s = |hit_s;
    assign match_t = |hit_t;

endmodule

// File: rtl/hazard_unit_mc.sv
// ID-stage hazard unit: multi-cycle load-use stalls, multi-cycle branch flush, redirect priority.
// Optional stall/flush statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int ADDR_WIDTH   = HZ_ADDR_WIDTH,
    parameter int LOAD_LAT     = 2,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [ADDR_WIDTH-1:0] regS_addr_id,
    input  logic [ADDR_WIDTH-1:0] regT_addr_id,
    input  logic                  regS_used_id,
    input  logic                  regT_used_id,
    input  logic                  mem_rd_en_ex,
    input  logic [ADDR_WIDTH-1:0] regT_addr_ex,
    input  logic                  branch,
    output logic                  clear_ctrl,
    output logic                  hold_if,
    output logic                  hold_pc,
    output logic                  if_flush,
    output logic [CNT_WIDTH-1:0]  stall_cycles,
    output logic [CNT_WIDTH-1:0]  flush_events
);

    localparam logic [HZ_FLUSH_CNT_W-1:0] FLUSH_LOAD = HZ_FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    logic                      match_s;
    logic                      match_t;
    logic                      stall_lw;
    logic                      flush_act;
    logic [HZ_FLUSH_CNT_W-1:0] flush_cnt;

    load_inflight_tracker #(.DEPTH(LOAD_LAT - 1)) u_trk (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld_valid (mem_rd_en_ex),
        .ld_addr  (regT_addr_ex),
        .src_s    (regS_addr_id),
        .src_t    (regT_addr_id),
        .match_s  (match_s),
        .match_t  (match_t)
    );

    // A branch during an active window restarts it rather than extending it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                flush_cnt <= '0;
        else if (branch)           flush_cnt <= FLUSH_LOAD;
        else if (flush_cnt != '0)  flush_cnt <= flush_cnt - 1'b1;
    end

    // rst_n gates the combinational paths so nothing escapes while reset is held.
    assign flush_act = rst_n && (branch || (flush_cnt != '0));
    assign stall_lw  = rst_n && id_valid &&
                       ((regS_used_id && (regS_addr_id != HZ_REG_ZERO) && match_s) ||
                        (regT_used_id && (regT_addr_id != HZ_REG_ZERO) && match_t));

    // Redirect wins: the wrong-path ID instruction is killed, not held.
    assign if_flush   = flush_act;
    assign clear_ctrl = flush_act || stall_lw;
    assign hold_if    = stall_lw && !flush_act;
    assign hold_pc    = stall_lw && !flush_act;

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (hold_pc && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_WIDTH'(1);
            if (branch  && (flush_events != '1)) flush_events <= flush_events + CNT_WIDTH'(1);
        end
    end
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Three hazard_unit_mc configurations on shared stimulus, checked against a history-based model.
module tb_hazard_unit_mc;

    localparam int ND  = 3;
    localparam int BIG = 1000;
    localparam int LAT [ND] = '{3, 1, 8};
    localparam int FC  [ND] = '{3, 1, 7};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] regS_addr_id = '0, regT_addr_id = '0, regT_addr_ex = '0;
    logic       regS_used_id = 1'b0, regT_used_id = 1'b0, mem_rd_en_ex = 1'b0, branch = 1'b0;

    logic [ND-1:0] clr, hif, hpc, ifl;
    logic [15:0]   sc [ND];
    logic [15:0]   fe [ND];

    int    n_cmp = 0, n_bad = 0;
    logic  rst_v = 1'b0;
    int    ld_q[$];
    int    since_br = BIG;
    int    sc_e [ND];
    int    fe_e [ND];

    always #5 clk = ~clk;

    hazard_unit_mc #(.LOAD_LAT(3), .FLUSH_CYCLES(3)) dut0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .regS_addr_id(regS_addr_id),
        .regT_addr_id(regT_addr_id), .regS_used_id(regS_used_id), .regT_used_id(regT_used_id),
        .mem_rd_en_ex(mem_rd_en_ex), .regT_addr_ex(regT_addr_ex), .branch(branch),
        .clear_ctrl(clr[0]), .hold_if(hif[0]), .hold_pc(hpc[0]), .if_flush(ifl[0]),
        .stall_cycles(sc[0]), .flush_events(fe[0]));

    hazard_unit_mc #(.LOAD_LAT(1), .FLUSH_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .regS_addr_id(regS_addr_id),
        .regT_addr_id(regT_addr_id), .regS_used_id(regS_used_id), .regT_used_id(regT_used_id),
        .mem_rd_en_ex(mem_rd_en_ex), .regT_addr_ex(regT_addr_ex), .branch(branch),
        .clear_ctrl(clr[1]), .hold_if(hif[1]), .hold_pc(hpc[1]), .if_flush(ifl[1]),
        .stall_cycles(sc[1]), .flush_events(fe[1]));

    hazard_unit_mc #(.LOAD_LAT(8), .FLUSH_CYCLES(7)) dut2 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .regS_addr_id(regS_addr_id),
        .regT_addr_id(regT_addr_id), .regS_used_id(regS_used_id), .regT_used_id(regT_used_id),
        .mem_rd_en_ex(mem_rd_en_ex), .regT_addr_ex(regT_addr_ex), .branch(branch),
        .clear_ctrl(clr[2]), .hold_if(hif[2]), .hold_pc(hpc[2]), .if_flush(ifl[2]),
        .stall_cycles(sc[2]), .flush_events(fe[2]));

    // A register is pending if a nonzero load to it sat in EX within the last lat cycles.
    function automatic bit pend(input int lat, input int a);
        if (a == 0) return 1'b0;
        for (int i = 0; i < lat && i < ld_q.size(); i++)
            if (ld_q[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input int d, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s dut%0d: got %0h expected %0h", tag, d, obs, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [4:0] s, input logic [4:0] t,
                       input logic su, input logic tu, input logic ld,
                       input logic [4:0] la, input logic br);
        bit fl, st;
        @(posedge clk); #1;
        rst_n = rst_v; id_valid = v; regS_addr_id = s; regT_addr_id = t;
        regS_used_id = su; regT_used_id = tu; mem_rd_en_ex = ld; regT_addr_ex = la; branch = br;
        if (!rst_v) begin
            ld_q.delete();
            since_br = BIG;
            for (int d = 0; d < ND; d++) begin sc_e[d] = 0; fe_e[d] = 0; end
        end else begin
            ld_q.push_front(ld ? int'(la) : 0);
            if (ld_q.size() > 8) void'(ld_q.pop_back());
            since_br = br ? 0 : ((since_br < BIG) ? since_br + 1 : BIG);
        end
        #1;
        for (int d = 0; d < ND; d++) begin
            fl = rst_v && (since_br < FC[d]);
            st = rst_v && v && ((su && pend(LAT[d], int'(s))) || (tu && pend(LAT[d], int'(t))));
            chk("if_flush",   d, 16'(ifl[d]), 16'(fl));
            chk("clear_ctrl", d, 16'(clr[d]), 16'(fl || st));
            chk("hold_if",    d, 16'(hif[d]), 16'(st && !fl));
            chk("hold_pc",    d, 16'(hpc[d]), 16'(st && !fl));
            chk("stall_cycles", d, sc[d], 16'(sc_e[d]));
            chk("flush_events", d, fe[d], 16'(fe_e[d]));
`ifdef HAZARD_STATS_EN
            if (rst_v && st && !fl && sc_e[d] < 16'hFFFF) sc_e[d]++;
            if (rst_v && br && fe_e[d] < 16'hFFFF) fe_e[d]++;
`endif
        end
    endtask

    initial begin
        for (int d = 0; d < ND; d++) begin sc_e[d] = 0; fe_e[d] = 0; end
        // Reset held with hazards and a branch on the inputs: everything must stay 0.
        rst_v = 1'b0;
        cyc(1, 5, 5, 1, 1, 1, 5, 1);
        cyc(1, 5, 5, 1, 1, 1, 5, 0);
        rst_v = 1'b1;
        // Load r5 in EX, ID reads S=5, then the load leaves EX.
        cyc(1, 5, 0, 1, 0, 1, 5, 0);
        cyc(1, 5, 0, 1, 0, 0, 0, 0);
        cyc(1, 5, 0, 1, 0, 0, 0, 0);
        cyc(1, 5, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
        // Load r7, ID reads only T=7 (S carries an unrelated register).
        cyc(1, 3, 7, 0, 1, 1, 7, 0);
        for (int i = 0; i < 9; i++) cyc(1, 3, 7, 0, 1, 0, 0, 0);
        // r0 load never stalls; an unused S that matches never stalls.
        cyc(1, 0, 0, 1, 1, 1, 0, 0);
        cyc(1, 9, 2, 0, 1, 1, 9, 0);
        cyc(0, 9, 9, 1, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
        // Branch pulse, second branch restarts the window, then idle.
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
        // Branch in the same cycle as a load-use stall, and during a later stall.
        cyc(1, 4, 0, 1, 0, 1, 4, 1);
        cyc(1, 4, 0, 1, 0, 0, 0, 0);
        cyc(1, 4, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
        // Reset during a flush with a load in flight; afterwards the tracker is empty.
        cyc(0, 0, 0, 0, 0, 1, 9, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        rst_v = 1'b0;
        cyc(1, 9, 9, 1, 1, 0, 0, 0);
        rst_v = 1'b1;
        cyc(1, 9, 9, 1, 1, 0, 0, 0);
        cyc(1, 9, 9, 1, 1, 0, 0, 0);
        // Randomized traffic on a small register range to provoke frequent hits.
        for (int i = 0; i < 1500; i++) begin
            rst_v = ($urandom_range(0, 99) != 0);
            cyc(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) == 0),
                5'($urandom_range(0, 7)), 1'($urandom_range(0, 9) == 0));
        end
        rst_v = 1'b1;
`ifdef HAZARD_STATS_EN
        // Continuous stall drives the stall counter into saturation, then reset clears it.
        for (int i = 0; i < 65540; i++) cyc(1, 5, 0, 1, 0, 1, 5, 0);
        rst_v = 1'b0;
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        rst_v = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
